// File: rtl/ef_decoder.sv
// EF up/down counter decoder: recovers E/F from successive 2-bit state codes,
// tracks net position and saturating move count, and flags illegal jumps.
module ef_decoder #(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       present,
  input  logic             clr_err,
  output logic             e_out,
  output logic             f_out,
  output logic             valid,
  output logic             step_err,
  output logic             err_sticky,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] moves
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_prev;
  logic [1:0]       r_legal_cnt;
  logic             r_e;
  logic             r_f;
  logic             r_valid;
  logic             r_step_err;
  logic             r_err_sticky;
  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] r_moves;

  logic [1:0]       w_delta;
  logic             w_move;
  logic             w_up;
  logic             w_illegal;
  logic [POS_W-1:0] w_pos_next;
  logic [POS_W-1:0] w_moves_next;

  // delta is the modulo-4 distance travelled since the previous sample.
  always_comb begin
    w_delta      = present - r_prev;
    w_move       = w_delta[0];
    w_up         = (w_delta == 2'd1);
    w_illegal    = (w_delta == 2'd2);
    w_pos_next   = w_up ? r_position + POS_W'(1) : r_position - POS_W'(1);
    w_moves_next = (&r_moves) ? r_moves : r_moves + POS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ACQUIRE;
      r_prev       <= 2'b00;
      r_legal_cnt  <= 2'd0;
      r_e          <= 1'b0;
      r_f          <= 1'b0;
      r_valid      <= 1'b0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_position   <= '0;
      r_moves      <= '0;
    end else begin
      r_prev     <= present;
      r_step_err <= 1'b0;
      // NOTE: non-blocking assignments resolve last-write-wins, so the set of
      // err_sticky in the illegal branches below overrides this clear.
      if (clr_err) r_err_sticky <= 1'b0;

      case (r_state)
        ACQUIRE: begin
          r_e     <= 1'b0;
          r_state <= TRACK;
          r_valid <= 1'b1;
        end

        TRACK: begin
          if (w_illegal) begin
            r_e          <= 1'b0;
            r_step_err   <= 1'b1;
            r_err_sticky <= 1'b1;
            r_legal_cnt  <= 2'd0;
            r_state      <= FAULT;
            r_valid      <= 1'b0;
          end else begin
            r_e <= w_move;
            if (w_move) begin
              r_f        <= w_up;
              r_position <= w_pos_next;
              r_moves    <= w_moves_next;
            end
          end
        end

        FAULT: begin
          if (w_illegal) begin
            r_e          <= 1'b0;
            r_step_err   <= 1'b1;
            r_err_sticky <= 1'b1;
            r_legal_cnt  <= 2'd0;
          end else begin
            r_e <= w_move;
            if (w_move) r_f <= w_up;
            // Second consecutive legal sample re-enters TRACK and counts this step.
            if (r_legal_cnt == 2'd1) begin
              r_legal_cnt <= 2'd0;
              r_state     <= TRACK;
              r_valid     <= 1'b1;
              if (w_move) begin
                r_position <= w_pos_next;
                r_moves    <= w_moves_next;
              end
            end else begin
              r_legal_cnt <= r_legal_cnt + 2'd1;
            end
          end
        end

        default: begin
          r_e     <= 1'b0;
          r_state <= ACQUIRE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign e_out      = r_e;
  assign f_out      = r_f;
  assign valid      = r_valid;
  assign step_err   = r_step_err;
  assign err_sticky = r_err_sticky;
  assign position   = r_position;
  assign moves      = r_moves;

endmodule

// File: tb/tb_ef_decoder.sv
// Directed self-checking bench for ef_decoder: inputs change on the falling
// edge, outputs are sampled 1 time unit after each rising edge.
module tb_ef_decoder;

  localparam int POS_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       present;
  logic             clr_err;
  logic             e_out;
  logic             f_out;
  logic             valid;
  logic             step_err;
  logic             err_sticky;
  logic [POS_W-1:0] position;
  logic [POS_W-1:0] moves;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] p;

  ef_decoder #(.POS_W(POS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .present    (present),
    .clr_err    (clr_err),
    .e_out      (e_out),
    .f_out      (f_out),
    .valid      (valid),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .position   (position),
    .moves      (moves)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] pv, input logic clr);
    @(negedge clk);
    present = pv;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  // Reset is applied together with clr_err and an arbitrary code to show priority.
  task automatic do_reset(input logic [1:0] pv);
    @(negedge clk);
    reset   = 1'b1;
    present = pv;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic expect_all(input string tag, input logic e, input logic f, input logic v,
                            input logic se, input logic st,
                            input logic [POS_W-1:0] pos, input logic [POS_W-1:0] mv);
    check({tag, ".e_out"},      32'(e_out),      32'(e));
    check({tag, ".f_out"},      32'(f_out),      32'(f));
    check({tag, ".valid"},      32'(valid),      32'(v));
    check({tag, ".step_err"},   32'(step_err),   32'(se));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
    check({tag, ".position"},   32'(position),   32'(pos));
    check({tag, ".moves"},      32'(moves),      32'(mv));
  endtask

  initial begin
    reset   = 1'b0;
    present = 2'b00;
    clr_err = 1'b0;

    // Reset state
    do_reset(2'b10);
    expect_all("reset", 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Up sequence 00,01,10,11,00
    step(2'b00, 0); expect_all("acq",  0, 0, 1, 0, 0, 8'h00, 8'h00);
    step(2'b01, 0); expect_all("up1",  1, 1, 1, 0, 0, 8'h01, 8'h01);
    step(2'b10, 0); expect_all("up2",  1, 1, 1, 0, 0, 8'h02, 8'h02);
    step(2'b11, 0); expect_all("up3",  1, 1, 1, 0, 0, 8'h03, 8'h03);
    step(2'b00, 0); expect_all("up4",  1, 1, 1, 0, 0, 8'h04, 8'h04);

    // Down from fresh TRACK: 00 -> 11 -> 10
    do_reset(2'b00);
    step(2'b00, 0); expect_all("acq2", 0, 0, 1, 0, 0, 8'h00, 8'h00);
    step(2'b11, 0); expect_all("dn1",  1, 0, 1, 0, 0, 8'hFF, 8'h01);
    step(2'b10, 0); expect_all("dn2",  1, 0, 1, 0, 0, 8'hFE, 8'h02);

    // Hold for 5 cycles: nothing moves, f holds 0
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 0);
      expect_all($sformatf("hold%0d", i), 0, 0, 1, 0, 0, 8'hFE, 8'h02);
    end

    // Walk down to 00, then illegal jump 00 -> 10
    step(2'b01, 0); expect_all("dn3",  1, 0, 1, 0, 0, 8'hFD, 8'h03);
    step(2'b00, 0); expect_all("dn4",  1, 0, 1, 0, 0, 8'hFC, 8'h04);
    step(2'b10, 0); expect_all("ill1", 0, 0, 0, 1, 1, 8'hFC, 8'h04);
    step(2'b10, 0); expect_all("flt1", 0, 0, 0, 0, 1, 8'hFC, 8'h04);
    step(2'b11, 0); expect_all("rec1", 1, 1, 1, 0, 1, 8'hFD, 8'h05);

    // clr_err alone clears; clr_err with an illegal jump keeps the flag set
    step(2'b00, 1); expect_all("clr",  1, 1, 1, 0, 0, 8'hFE, 8'h06);
    step(2'b10, 1); expect_all("ill2", 0, 1, 0, 1, 1, 8'hFE, 8'h06);

    // FAULT: illegal re-pulses and restarts the legal count; position frozen
    step(2'b00, 0); expect_all("ill3", 0, 1, 0, 1, 1, 8'hFE, 8'h06);
    step(2'b11, 0); expect_all("flt2", 1, 0, 0, 0, 1, 8'hFE, 8'h06);
    step(2'b01, 0); expect_all("ill4", 0, 0, 0, 1, 1, 8'hFE, 8'h06);
    step(2'b10, 0); expect_all("flt3", 1, 1, 0, 0, 1, 8'hFE, 8'h06);
    step(2'b11, 0); expect_all("rec2", 1, 1, 1, 0, 1, 8'hFF, 8'h07);

    // Reset from FAULT
    step(2'b01, 0); expect_all("ill5", 0, 1, 0, 1, 1, 8'hFF, 8'h07);
    do_reset(2'b11);
    expect_all("rst_flt", 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Positive wrap and moves saturation
    step(2'b00, 0);
    p = 2'b00;
    for (int i = 0; i < 127; i++) begin p = p + 2'd1; step(p, 0); end
    expect_all("pos7f", 1, 1, 1, 0, 0, 8'h7F, 8'h7F);
    p = p + 2'd1; step(p, 0);
    expect_all("pos80", 1, 1, 1, 0, 0, 8'h80, 8'h80);
    for (int i = 0; i < 127; i++) begin p = p + 2'd1; step(p, 0); end
    expect_all("movff", 1, 1, 1, 0, 0, 8'hFF, 8'hFF);
    p = p + 2'd1; step(p, 0);
    p = p + 2'd1; step(p, 0);
    expect_all("sat1", 1, 1, 1, 0, 0, 8'h01, 8'hFF);
    p = p - 2'd1; step(p, 0);
    expect_all("sat2", 1, 0, 1, 0, 0, 8'h00, 8'hFF);

    // Negative wrap: most negative minus one
    do_reset(2'b01);
    step(2'b01, 0);
    p = 2'b01;
    for (int i = 0; i < 128; i++) begin p = p - 2'd1; step(p, 0); end
    expect_all("neg80", 1, 0, 1, 0, 0, 8'h80, 8'h80);
    p = p - 2'd1; step(p, 0);
    expect_all("neg7f", 1, 0, 1, 0, 0, 8'h7F, 8'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ef_decoder.md
EF_DECODER -- requirements
Module: ef_decoder

Interface
REQ-001 Parameter: POS_W, default 8, width of the position and move counters.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: present  input  2  observed state code from an EF up/down counter (00,01,10,11).
REQ-005 Port: clr_err  input  1  clears err_sticky when high at a rising edge.
REQ-006 Port: e_out  output  1  recovered E (1 = counter moved this sample).
REQ-007 Port: f_out  output  1  recovered F (1 = up, 0 = down); holds its last value when e_out=0.
REQ-008 Port: valid  output  1  high only in state TRACK.
REQ-009 Port: step_err  output  1  one-cycle pulse on an illegal transition.
REQ-010 Port: err_sticky  output  1  latched illegal-transition flag.
REQ-011 Port: position  output  POS_W  two's-complement net step count.
REQ-012 Port: moves  output  POS_W  unsigned count of legal moves in TRACK; saturates at all-ones.

Function
REQ-013 The block SHALL hold a registered copy prev of present; every non-reset edge SHALL do prev <= present.
REQ-014 delta SHALL be (present - prev) mod 4, evaluated at each edge; outputs SHALL be registered, so each output reflects the prev->present transition with 1-cycle latency.
REQ-015 delta=0: e_out=0, f_out holds, position and moves unchanged.
REQ-016 delta=1: e_out=1, f_out=1, position +1 (in TRACK only).
REQ-017 delta=3: e_out=1, f_out=0, position -1 (in TRACK only).
REQ-018 delta=2 (illegal): step_err=1 for exactly one cycle, err_sticky=1, e_out=0, f_out holds, position and moves unchanged.
REQ-019 position SHALL wrap modulo 2^POS_W (max positive +1 -> most negative, most negative -1 -> max positive).
REQ-020 moves SHALL increment on delta 1 or 3 in TRACK and SHALL stay at 2^POS_W-1 once reached.
REQ-021 FSM states: ACQUIRE, TRACK, FAULT.
REQ-022 ACQUIRE: capture prev, no decode, e_out=0; next edge -> TRACK unconditionally.
REQ-023 TRACK: decode per REQ-015..018; delta=2 -> FAULT, legal_cnt cleared.
REQ-024 FAULT: e_out/f_out decode continues, position and moves frozen; legal delta (0,1,3) increments a 2-bit legal_cnt; delta=2 clears legal_cnt and re-pulses step_err.
REQ-025 FAULT -> TRACK on the edge where legal_cnt would reach 2; the position/moves update for that edge's delta SHALL be applied.
REQ-026 clr_err=1 SHALL clear err_sticky at that edge, except when delta=2 at the same edge, in which case err_sticky SHALL be 1 (error wins).
REQ-027 clr_err SHALL NOT affect FSM state, position or moves.

Reset
REQ-028 reset=1 at a rising edge SHALL force state ACQUIRE, prev=00, legal_cnt=0, e_out=0, f_out=0, valid=0, step_err=0, err_sticky=0, position=0, moves=0.
REQ-029 reset SHALL take priority over every other input including clr_err, and SHALL take effect mid-operation from any state.
REQ-030 Before the first reset edge, outputs are undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-031 Reset, then present 00,01,10,11,00 on successive edges -> after the first edge valid=1; e_out=1, f_out=1 on each following edge; final position=4, moves=4.
REQ-032 From TRACK with present=00, drive 11,10 -> e_out=1, f_out=0 twice; position=-2 (0xFE for POS_W=8), moves=2.
REQ-033 present held constant 5 cycles -> e_out=0, f_out holds previous value, position and moves unchanged, valid=1.
REQ-034 present 00 -> 10 -> step_err pulses 1 cycle, err_sticky=1, valid=0; then 10,11 -> after the 2nd legal sample valid=1, position +1 from the 11 step only.
REQ-035 position=0x7F, one up step -> position=0x80; moves at 0xFF with further steps -> moves stays 0xFF.
REQ-036 clr_err=1 on the same edge as a delta=2 -> err_sticky=1; clr_err=1 alone on a later edge -> err_sticky=0; reset asserted in FAULT -> all outputs per REQ-028 on the next edge.
